// File: rtl/sg_mag_arbiter.sv
// ---------------------------------------------------------------------------
// sg_mag_arbiter
//   Two-requester arbiter in front of a single 4-bit sign-magnitude adder.
//   A granted requester's operands are captured on the grant edge, the sum is
//   computed in the following cycle, and a one-cycle done pulse is returned.
//   The grant is then held until the requester drops its request.
//
// Parameters
//   FIXED_PRIO  0: round-robin on ties, 1: requester 0 always wins ties
//
// Ports
//   clk           clock, rising-edge
//   rst_n         synchronous active-low reset
//   req0, req1    level requests (four-phase)
//   a0, b0        requester 0 operands  (bit 3 sign, bits 2:0 magnitude)
//   a1, b1        requester 1 operands  (same format)
//   gnt0, gnt1    registered grants, mutually exclusive
//   done0, done1  registered one-cycle result-valid pulses
//   res           registered result (bit 3 sign, bits 2:0 magnitude)
//   ovf           registered magnitude overflow flag
//   busy          high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module sg_mag_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic       req1,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic [3:0] res,
    output logic       ovf,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2,
        WAIT = 2'd3
    } state_t;

    state_t     state, state_n;
    logic       gnt0_n, gnt1_n, done0_n, done1_n, ovf_n;
    logic [3:0] res_n;
    logic [3:0] op_a, op_b, op_a_n, op_b_n;
    logic       win, win_n;     // requester currently being served
    logic       last, last_n;   // requester served most recently
    logic       pick;

    // ALU outputs
    logic       alu_ovf;
    logic [3:0] alu_res;
    logic [3:0] sum;
    logic [2:0] mag;
    logic       sgn;

    // Sign-magnitude addition of the latched operands
    always_comb begin
        sum     = {1'b0, op_a[2:0]} + {1'b0, op_b[2:0]};
        mag     = '0;
        sgn     = 1'b0;
        alu_ovf = 1'b0;
        if (op_a[3] == op_b[3]) begin
            mag     = sum[2:0];
            sgn     = op_a[3];
            alu_ovf = sum[3];
        end else if (op_a[2:0] >= op_b[2:0]) begin
            mag = op_a[2:0] - op_b[2:0];
            sgn = op_a[3];
        end else begin
            mag = op_b[2:0] - op_a[2:0];
            sgn = op_b[3];
        end
        // A zero result without overflow is always reported as +0
        if (!alu_ovf && mag == 3'd0) begin
            alu_res = '0;
        end else begin
            alu_res = {sgn, mag};
        end
    end

    // Arbitration: a lone requester wins; on a tie either requester 0
    // (fixed mode) or the one not served last (round-robin).
    always_comb begin
        if (req0 && req1) begin
            pick = FIXED_PRIO ? 1'b0 : ~last;
        end else begin
            pick = req1;
        end
    end

    always_comb begin
        state_n = state;
        gnt0_n  = gnt0;
        gnt1_n  = gnt1;
        done0_n = 1'b0;
        done1_n = 1'b0;
        res_n   = res;
        ovf_n   = ovf;
        op_a_n  = op_a;
        op_b_n  = op_b;
        win_n   = win;
        last_n  = last;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    win_n   = pick;
                    gnt0_n  = ~pick;
                    gnt1_n  = pick;
                    op_a_n  = pick ? a1 : a0;
                    op_b_n  = pick ? b1 : b0;
                    state_n = EXEC;
                end
            end
            EXEC: begin
                res_n   = alu_res;
                ovf_n   = alu_ovf;
                done0_n = ~win;
                done1_n = win;
                state_n = RESP;
            end
            RESP: begin
                state_n = WAIT;
            end
            WAIT: begin
                if (!(win ? req1 : req0)) begin
                    gnt0_n  = 1'b0;
                    gnt1_n  = 1'b0;
                    last_n  = win;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            res   <= '0;
            ovf   <= 1'b0;
            op_a  <= '0;
            op_b  <= '0;
            win   <= 1'b0;
            last  <= 1'b0;
        end else begin
            state <= state_n;
            gnt0  <= gnt0_n;
            gnt1  <= gnt1_n;
            done0 <= done0_n;
            done1 <= done1_n;
            res   <= res_n;
            ovf   <= ovf_n;
            op_a  <= op_a_n;
            op_b  <= op_b_n;
            win   <= win_n;
            last  <= last_n;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_sg_mag_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sg_mag_arbiter
//   Directed bench for sg_mag_arbiter. One instance in round-robin mode
//   carries most vectors; a second instance in fixed-priority mode shares
//   operands and reset but has its own requests, used for the tie tests.
// ---------------------------------------------------------------------------
module tb_sg_mag_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1, req0_f, req1_f;
    logic [3:0] a0, b0, a1, b1;

    logic       gnt0, gnt1, done0, done1, ovf, busy;
    logic [3:0] res;
    logic       gnt0_f, gnt1_f, done0_f, done1_f, ovf_f, busy_f;
    logic [3:0] res_f;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sg_mag_arbiter #(.FIXED_PRIO(1'b0)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .res(res), .ovf(ovf), .busy(busy)
    );

    sg_mag_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0(req0_f), .a0(a0), .b0(b0),
        .req1(req1_f), .a1(a1), .b1(b1),
        .gnt0(gnt0_f), .gnt1(gnt1_f), .done0(done0_f), .done1(done1_f),
        .res(res_f), .ovf(ovf_f), .busy(busy_f)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single-requester transaction on the round-robin instance. Operands are
    // scrambled right after the grant edge; the request is dropped in EXEC
    // unless hold is set, in which case it is held one extra WAIT cycle.
    task automatic run_txn(input bit who, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] er, input bit eo, input bit hold);
        logic [1:0] onehot;
        onehot = who ? 2'b10 : 2'b01;
        if (who) begin req1 = 1'b1; a1 = a; b1 = b; end
        else     begin req0 = 1'b1; a0 = a; b0 = b; end
        tick();
        check("gnt_at_grant", {6'd0, gnt1, gnt0}, {6'd0, onehot});
        check("busy_exec", {7'd0, busy}, 8'd1);
        check("done_exec", {6'd0, done1, done0}, 8'd0);
        a0 = ~a; b0 = ~b; a1 = ~a; b1 = ~b;
        if (!hold) begin req0 = 1'b0; req1 = 1'b0; end
        tick();
        check("done_resp", {6'd0, done1, done0}, {6'd0, onehot});
        check("res", {4'd0, res}, {4'd0, er});
        check("ovf", {7'd0, ovf}, {7'd0, eo});
        tick();
        check("done_wait", {6'd0, done1, done0}, 8'd0);
        check("gnt_wait", {6'd0, gnt1, gnt0}, {6'd0, onehot});
        if (hold) begin
            tick();
            check("gnt_held", {6'd0, gnt1, gnt0}, {6'd0, onehot});
            check("busy_held", {7'd0, busy}, 8'd1);
            req0 = 1'b0; req1 = 1'b0;
        end
        tick();
        check("gnt_idle", {6'd0, gnt1, gnt0}, 8'd0);
        check("busy_idle", {7'd0, busy}, 8'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; req0_f = 1'b0; req1_f = 1'b0;
        a0 = 4'h0; b0 = 4'h0; a1 = 4'h0; b1 = 4'h0;
        tick();
        tick();
        check("rst_outs", {gnt0, gnt1, done0, done1, ovf, busy, 2'b00}, 8'd0);
        check("rst_res", {4'd0, res}, 8'd0);
        check("rst_fp_outs", {gnt0_f, gnt1_f, done0_f, done1_f, ovf_f, busy_f, res_f[1:0]}, 8'd0);
        rst_n = 1'b1;

        // Arithmetic vectors
        run_txn(1'b0, 4'b0011, 4'b0010, 4'b0101, 1'b0, 1'b0); // +3 + +2
        run_txn(1'b1, 4'b0110, 4'b0101, 4'b0011, 1'b1, 1'b0); // +6 + +5 overflow
        run_txn(1'b1, 4'b1101, 4'b0010, 4'b1011, 1'b0, 1'b0); // -5 + +2
        run_txn(1'b0, 4'b1100, 4'b0100, 4'b0000, 1'b0, 1'b0); // -4 + +4
        run_txn(1'b0, 4'b1000, 4'b1000, 4'b0000, 1'b0, 1'b0); // -0 + -0
        run_txn(1'b1, 4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b0); // +4 + +4 -> 8
        run_txn(1'b0, 4'b1111, 4'b1111, 4'b1110, 1'b1, 1'b0); // -7 + -7
        run_txn(1'b1, 4'b0010, 4'b1110, 4'b1100, 1'b0, 1'b0); // +2 + -6
        run_txn(1'b1, 4'b0001, 4'b1001, 4'b0000, 1'b0, 1'b1); // +1 + -1, held

        // Ties: round-robin alternates 1,0,1,0 after reset; fixed gives 0
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        a0 = 4'b0001; b0 = 4'b0001;   // +1 + +1 = 0010
        a1 = 4'b0011; b1 = 4'b1111;   // +3 + -7 = 1100
        req0 = 1'b1; req1 = 1'b1; req0_f = 1'b1; req1_f = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic w;
            w = (i % 2 == 0);
            tick();
            check("tie_rr_gnt", {6'd0, gnt1, gnt0}, w ? 8'd2 : 8'd1);
            check("tie_fp_gnt", {6'd0, gnt1_f, gnt0_f}, 8'd1);
            tick();
            check("tie_rr_done", {6'd0, done1, done0}, w ? 8'd2 : 8'd1);
            check("tie_rr_res", {4'd0, res}, w ? 8'h0c : 8'h02);
            check("tie_fp_done", {6'd0, done1_f, done0_f}, 8'd1);
            check("tie_fp_res", {4'd0, res_f}, 8'h02);
            tick();
            if (w) req1 = 1'b0; else req0 = 1'b0;
            req0_f = 1'b0;
            tick();
            check("tie_idle", {6'd0, busy, busy_f}, 8'd0);
            req0 = 1'b1; req1 = 1'b1; req0_f = 1'b1;
        end
        req0 = 1'b0; req1 = 1'b0; req0_f = 1'b0; req1_f = 1'b0;
        tick();
        tick();

        // Reset during RESP, then a fresh transaction with new operands
        req0 = 1'b1; a0 = 4'b0011; b0 = 4'b0001;   // +3 + +1 = 0100
        tick();
        check("rr_gnt0", {6'd0, gnt1, gnt0}, 8'd1);
        tick();
        check("rr_done0", {6'd0, done1, done0}, 8'd1);
        check("rr_res", {4'd0, res}, 8'h04);
        rst_n = 1'b0;
        a0 = 4'b0001; b0 = 4'b0001;                 // +1 + +1 = 0010
        tick();
        check("rr_cleared", {gnt0, gnt1, done0, done1, ovf, busy, 2'b00}, 8'd0);
        check("rr_res_cleared", {4'd0, res}, 8'd0);
        rst_n = 1'b1;
        tick();
        check("rr_regrant", {6'd0, gnt1, gnt0}, 8'd1);
        req0 = 1'b0;
        tick();
        check("rr_redone", {6'd0, done1, done0}, 8'd1);
        check("rr_reres", {4'd0, res}, 8'h02);
        tick();
        tick();
        check("rr_end_idle", {6'd0, gnt0, busy}, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sg_mag_arbiter.md
SG_MAG_ARBITER -- requirements
Module: sg_mag_arbiter

Interface
REQ-001 Parameter FIXED_PRIO, default 0; 0 = round-robin between requesters, 1 = requester 0 always wins a tie.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req0  input  1  requester 0 transaction request (level, four-phase).
REQ-005 a0, b0  input  4 each  requester 0 sign-magnitude operands; bit 3 sign, bits 2:0 magnitude.
REQ-006 req1  input  1  requester 1 transaction request.
REQ-007 a1, b1  input  4 each  requester 1 operands, same format.
REQ-008 gnt0, gnt1  output  1 each  registered grant; at most one high.
REQ-009 done0, done1  output  1 each  registered one-cycle result-valid pulse to the granted requester.
REQ-010 res  output  4  registered result; bit 3 sign, bits 2:0 magnitude.
REQ-011 ovf  output  1  registered magnitude overflow flag for res.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 FSM states: IDLE, EXEC, RESP, WAIT.
REQ-014 IDLE: no req -> stay; any req -> EXEC, assert the winner's gnt, latch the winner's a/b into internal operand registers.
REQ-015 Arbitration: only one req -> that requester; both -> requester 0 if FIXED_PRIO=1, else requester not served last (pointer).
REQ-016 EXEC: compute from latched operands; load res/ovf; -> RESP.
REQ-017 RESP: winner's done high for exactly this cycle; -> WAIT.
REQ-018 WAIT: gnt held; winner's req low at edge -> IDLE, gnt low, pointer marks winner as last served; else stay.
REQ-019 Latency: req sampled at edge N -> gnt high after N; res/ovf valid and done high after N+1 until N+2; minimum 4 cycles per transaction (back to IDLE no earlier than edge N+3).
REQ-020 Operands sampled only at the grant edge; later a/b changes have no effect on the current transaction.
REQ-021 Requester dropping req during EXEC/RESP: transaction completes, done still pulses, WAIT exits on next edge.
REQ-022 Loser's request stays pending, no gnt/done; served in a later IDLE.
REQ-023 Equal signs: magnitude = ma + mb (4-bit); sign = common sign; sum > 7 -> ovf=1, res[2:0] = sum[2:0], res[3] = operand sign.
REQ-024 Different signs: magnitude = larger minus smaller, sign = sign of larger-magnitude operand; ovf=0.
REQ-025 Zero normalization: ovf=0 and result magnitude 0 -> res = 4'b0000 (no negative zero), covering equal magnitudes of opposite sign and -0 + -0.
REQ-026 res/ovf hold last value outside EXEC updates; meaningful only when done is/was high for that transaction.
REQ-027 gnt0 and gnt1 never high in the same cycle; done only to the currently granted requester.

Reset
REQ-028 rst_n low at a rising edge -> IDLE; gnt0, gnt1, done0, done1, ovf, busy = 0; res = 4'b0000; pointer = requester 0 considered last served (requester 1 wins first tie in round-robin mode).
REQ-029 Reset in any state aborts the transaction without a done pulse; first post-reset edge with rst_n high treated as IDLE.

Verification
REQ-030 req0, a0=4'b0011 (+3), b0=4'b0010 (+2) -> gnt0 after edge N, done0 pulse after N+1, res=4'b0101, ovf=0.
REQ-031 req1, a1=4'b0110 (+6), b1=4'b0101 (+5) -> res=4'b0011, ovf=1; a1=4'b1101 (-5), b1=4'b0010 (+2) -> res=4'b1011, ovf=0.
REQ-032 a0=4'b1100 (-4), b0=4'b0100 (+4) -> res=4'b0000; a0=4'b1000, b0=4'b1000 -> res=4'b0000, ovf=0.
REQ-033 req0 and req1 held high continuously, FIXED_PRIO=0, each dropped one cycle after its done -> grants alternate 1,0,1,0; FIXED_PRIO=1 -> 0 first each tie.
REQ-034 rst_n low during RESP -> no done pulse, all outputs 0 next cycle; req0 still high -> new transaction with fresh operands.
REQ-035 Operands change the cycle after grant, req dropped in EXEC -> result uses grant-edge operands, done still pulses, IDLE two edges after done.
